// File: rtl/dsp_pkg.sv
// dsp_pkg: types and constants shared by dsp and its serial input framer.
// Holds the framer state encoding and the common word geometry.
package dsp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HUNT,
      SHIFT,
      DONE
   } state_t;

   localparam int default_bus_width = 24;
   localparam int word_idx_w = 8;

endpackage

// File: rtl/dsp_framer.sv
// dsp_framer: hunts for frame sync in a serial stream and packs MSB-first
// bits into bus_width words, strobing each one out to dsp with we.
module dsp_framer
   import dsp_pkg::*;
#(
   parameter int   bus_width       = default_bus_width,
   parameter int   words_per_frame = 8,
   parameter logic rst_val         = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic                  sdata,
   input  logic                  svalid,
   input  logic                  sframe,
   output logic [bus_width-1:0]  word,
   output logic                  we,
   output logic [word_idx_w-1:0] word_idx,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  sync_err
);

   localparam int cw = $clog2(bus_width);

   localparam logic [cw-1:0] bit_one  = cw'(1);
   localparam logic [cw-1:0] bit_last = cw'(bus_width - 1);

   localparam logic [word_idx_w-1:0] wrd_one  = word_idx_w'(1);
   localparam logic [word_idx_w-1:0] wrd_last = word_idx_w'(words_per_frame - 1);

   typedef logic [bus_width-2:0] sh_t;

   state_t                  state;
   state_t                  state_n;
   sh_t                     shreg;
   logic [cw-1:0]           bit_cnt;
   logic [word_idx_w-1:0]   wcnt;
   logic [bus_width-1:0]    nxt;
   logic                    word_end;
   logic                    frame_end;
   logic                    resync;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state; everything freezes while en is low.
   always_comb begin
      state_n = state;
      if (en) begin
         unique case (state)
            IDLE:    if (start) state_n = HUNT;
            HUNT:    if (svalid && sframe) state_n = SHIFT;
            SHIFT:   if (svalid && frame_end) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // Position decode of the current bit and the busy flag.
   always_comb begin
      nxt       = {shreg, sdata};
      word_end  = (bit_cnt == bit_last);
      frame_end = word_end && (wcnt == wrd_last);
      resync    = sframe && ((bit_cnt != '0) || (wcnt != '0))
                  && !frame_end;
      busy      = (state != IDLE);
   end

   // Shift register, counters and registered word outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         wcnt       <= '0;
         word       <= {bus_width{rst_val}};
         we         <= 1'b0;
         word_idx   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         we         <= 1'b0;
         frame_done <= 1'b0;
         if (en) begin
            unique case (state)
               IDLE: begin
                  sync_err <= 1'b0;
                  bit_cnt  <= '0;
                  wcnt     <= '0;
               end
               HUNT: begin
                  if (svalid && sframe) begin
                     shreg   <= sh_t'(sdata);
                     bit_cnt <= bit_one;
                  end
               end
               SHIFT: begin
                  if (svalid) begin
                     if (resync) begin
                        sync_err <= 1'b1;
                        shreg    <= sh_t'(sdata);
                        bit_cnt  <= bit_one;
                        wcnt     <= '0;
                     end else if (word_end) begin
                        word     <= nxt;
                        we       <= 1'b1;
                        word_idx <= wcnt;
                        bit_cnt  <= '0;
                        if (!frame_end) wcnt <= wcnt + wrd_one;
                     end else begin
                        shreg   <= nxt[bus_width-2:0];
                        bit_cnt <= bit_cnt + bit_one;
                     end
                  end
               end
               DONE: frame_done <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/dsp_framer.md
# dsp_framer

Serial-to-parallel input stage that sits directly upstream of the `dsp` block. It hunts for a frame sync in a serial sample stream and assembles MSB-first bits into `bus_width`-wide words. For each completed word it presents the word on `word` with a one-cycle `we` strobe, wired straight to `dsp.din`/`dsp.we`. It counts words per frame, signals frame completion, and flags resynchronisation errors.

## Interface
Parameters:
- `bus_width`, 24, word width in bits; must match `dsp.bus_width`; legal range 2..64
- `words_per_frame`, 8, words assembled per frame before returning to idle; legal range 1..256
- `rst_val`, 1'b0, bit value replicated across `word` at reset

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  clock enable; when low, all state, counters and outputs hold and `svalid` is ignored
- `start`  in  1  arms a frame capture; sampled in IDLE only
- `sdata`  in  1  serial data bit, MSB of each word first
- `svalid`  in  1  `sdata` is valid this cycle
- `sframe`  in  1  frame sync; qualified by `svalid`; marks the first bit of a frame
- `word`  out  bus_width  assembled word; registered; holds until the next word
- `we`  out  1  one-cycle strobe, `word` is new this cycle
- `word_idx`  out  8  index of the word on `word` within the frame (0..words_per_frame-1)
- `busy`  out  1  state is not IDLE
- `frame_done`  out  1  one-cycle pulse after the last word of a frame
- `sync_err`  out  1  sticky; `sframe` seen mid-frame

## Operation
- States: IDLE, HUNT, SHIFT, DONE.
- IDLE:
  - `start && en` -> HUNT.
  - Clears `sync_err`, `bit_cnt` and `wcnt`.
- HUNT:
  - `svalid && sframe` -> SHIFT.
  - That bit is loaded as bit 0 of the shift register, and `bit_cnt` becomes 1.
  - All other bits are discarded.
- SHIFT, on each cycle with `svalid`:
  - `shreg <= {shreg[bus_width-2:0], sdata}` and `bit_cnt++`.
  - When `bit_cnt == bus_width-1`, the current bit completes the word: `word <= {shreg[bus_width-2:0], sdata}`, `we <= 1`, `word_idx <= wcnt`, `bit_cnt <= 0`.
  - If that word was number `words_per_frame-1`, go to DONE; otherwise `wcnt++`.
- `sframe && svalid` in SHIFT with `bit_cnt != 0` or `wcnt != 0` (mid-frame resync):
  - Set `sync_err`.
  - Discard the partial word and reset `wcnt` to 0.
  - Treat the bit as the first bit of a new frame (`bit_cnt` = 1). No `we`.
- `sframe` coincident with the bit that completes the final word: the word completes normally and the sync is ignored.
- DONE: `frame_done <= 1` for one cycle, then -> IDLE unconditionally. A `start` held high re-arms on the following IDLE cycle.
- `en` low: every register holds, including mid-word. `we` and `frame_done` are forced low while `en` is low and resume as pulses only on new events.
- `svalid` low in SHIFT: no shift, no count change.
- Reset values:
  - State IDLE; `bit_cnt` and `wcnt` 0.
  - `word` = {bus_width{rst_val}}; `we`, `frame_done`, `sync_err`, `busy` 0; `word_idx` 0.
- Reset mid-frame: partial word lost, no `we`, no `frame_done`.
- Counter widths:
  - `bit_cnt` is $clog2(bus_width) bits.
  - `wcnt` is 8 bits; it never exceeds `words_per_frame-1`.

## Timing
- Latency: a bit sampled at edge N that completes a word gives `word`/`we` valid after edge N, i.e. during cycle N+1. `we` is high for exactly one cycle.
- Minimum spacing between `we` pulses is `bus_width` cycles (with `svalid` continuously high).
- `frame_done` asserts the cycle after the final `we`.
- `busy` is registered and goes high the cycle after `start` is accepted.
- `start` to first possible `we`: 1 cycle (HUNT entry) + `bus_width` valid bits.
- Total frame time with continuous `svalid`: `words_per_frame*bus_width` cycles from the `sframe` bit, plus 1 cycle for DONE.

## Structure
- Shared package `dsp_pkg`:
  - state enum (IDLE/HUNT/SHIFT/DONE)
  - default `bus_width` constant, shared with `dsp`
  - `word_idx` width constant (8)
- Single module with no sub-module. The shift register, two counters and FSM are small enough to keep flat.

## Test plan
Use `bus_width`=24 and `words_per_frame`=4 unless noted.
- Reset then idle: hold `rst` 2 cycles -> `word`=24'h000000, `we`=0, `busy`=0. Apply `start` and 20 bits without `sframe` -> no `we`; `busy`=1 (HUNT).
- Nominal frame: `start`, then `sframe` on the first of 96 continuous bits encoding 24'hA5C3F0, 24'h123456, 24'hFFFFFF, 24'h000001 -> four `we` pulses 24 cycles apart with those words and `word_idx` 0..3, `frame_done` one cycle after the 4th, `busy`=0 the next cycle.
- Gapped input and enable: `svalid` toggling every other cycle and `en` low for 5 cycles mid-word -> same words as the nominal case; `we` spacing 48 cycles plus the 5-cycle stall on the affected word.
- Resync: `sframe` re-asserted at bit 10 of word 1 -> `sync_err`=1 and stays set. The following 96 bits yield `word_idx` 0..3 with no `we` for the truncated word. `sync_err` clears on the next IDLE.
- Reset mid-frame: `rst` during word 2 -> no further `we` or `frame_done`. Outputs return to reset values; a fresh `start` and frame captures correctly.
- Edge parameters: `bus_width`=2 and `words_per_frame`=1 -> `we` every 2 valid bits. `frame_done` follows the first word; a `start` held high re-arms automatically.
